// File: rtl/avg_threshold_monitor.sv
// avg_threshold_monitor: debounced hysteresis over-limit detector with latched fault and peak hold.
// Define AVG_MON_TRIP_CNT_EN to add the saturating trip_cnt output.
module avg_threshold_monitor #(
   parameter int DW    = 18,
   parameter int US    = 0,
   parameter int DEB_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ENA,
   input  logic [DW-1:0]    avg,
   input  logic [DW-1:0]    thr_hi,
   input  logic [DW-1:0]    thr_lo,
   input  logic [DEB_W-1:0] deb_cnt,
   input  logic             clr,
   output logic             over,
   output logic             fault,
   output logic             fault_pulse,
   output logic [DW-1:0]    peak
`ifdef AVG_MON_TRIP_CNT_EN
   ,
   output logic [15:0]      trip_cnt
`endif
);
   typedef enum logic [1:0] {OK, PEND_TRIP, TRIPPED, PEND_REL} state_t;
   localparam logic [DW-1:0] PEAK_RST = (US != 0) ? {DW{1'b0}} : {1'b1, {(DW-1){1'b0}}};
   function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (US != 0) ? (a > b) : ($signed(a) > $signed(b));
   endfunction
   state_t           state, state_nxt;
   logic [DEB_W-1:0] cnt, cnt_nxt, n_eff;
   logic [DEB_W:0]   cnt_inc;
   logic             ena_old, ev, hi_cross, lo_cross, done, trip;
   always_comb begin
      ev       = ENA & ~ena_old;
      hi_cross = gt(avg, thr_hi);
      lo_cross = gt(thr_lo, avg);
      n_eff    = (deb_cnt == '0) ? {{(DEB_W-1){1'b0}}, 1'b1} : deb_cnt;
      cnt_inc  = {1'b0, cnt} + 1'b1;
      done     = cnt_inc >= {1'b0, n_eff};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= OK;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   // cnt is always 0 in OK/TRIPPED, so the pending-state arithmetic covers the N=1 shortcut too
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (ev)
         case (state)
            OK, PEND_TRIP: begin
               state_nxt = hi_cross ? (done ? TRIPPED : PEND_TRIP) : OK;
               cnt_nxt   = (hi_cross && !done) ? cnt_inc[DEB_W-1:0] : '0;
            end
            TRIPPED, PEND_REL: begin
               state_nxt = lo_cross ? (done ? OK : PEND_REL) : TRIPPED;
               cnt_nxt   = (lo_cross && !done) ? cnt_inc[DEB_W-1:0] : '0;
            end
         endcase
   end
   always_comb begin
      over = (state == TRIPPED) || (state == PEND_REL);
      trip = ev && (state_nxt == TRIPPED) && ((state == OK) || (state == PEND_TRIP));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ena_old     <= 1'b0;
         fault       <= 1'b0;
         fault_pulse <= 1'b0;
         peak        <= PEAK_RST;
      end else begin
         ena_old     <= ENA;
         fault       <= trip | (fault & ~clr);
         fault_pulse <= trip;
         peak        <= (ev && (clr || gt(avg, peak))) ? avg : clr ? PEAK_RST : peak;
      end
`ifdef AVG_MON_TRIP_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         trip_cnt <= '0;
      else
         trip_cnt <= clr ? {15'd0, trip} : (trip && trip_cnt != 16'hFFFF) ? trip_cnt + 16'd1 : trip_cnt;
`endif
endmodule

// File: tb/tb_avg_threshold_monitor.sv
// tb_avg_threshold_monitor: directed checks of avg_threshold_monitor, signed and unsigned builds.
module tb_avg_threshold_monitor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ENA = 1'b0;
   logic [17:0] avg = '0;
   logic [17:0] thr_hi = 18'd1000;
   logic [17:0] thr_lo = 18'd800;
   logic [7:0]  deb_cnt = 8'd3;
   logic        clr = 1'b0;
   logic        over, fault, fault_pulse;
   logic [17:0] peak;
   logic        over_u, fault_u, fault_pulse_u;
   logic [17:0] peak_u;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef AVG_MON_TRIP_CNT_EN
   logic [15:0] trip_cnt, trip_cnt_u;
`endif
   always #5 clk = ~clk;

   avg_threshold_monitor #(.DW(18), .US(0), .DEB_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ENA(ENA), .avg(avg), .thr_hi(thr_hi), .thr_lo(thr_lo),
      .deb_cnt(deb_cnt), .clr(clr), .over(over), .fault(fault), .fault_pulse(fault_pulse), .peak(peak)
`ifdef AVG_MON_TRIP_CNT_EN
      , .trip_cnt(trip_cnt)
`endif
   );

   avg_threshold_monitor #(.DW(18), .US(1), .DEB_W(8)) dut_u (
      .clk(clk), .rst_n(rst_n), .ENA(ENA), .avg(avg), .thr_hi(thr_hi), .thr_lo(thr_lo),
      .deb_cnt(deb_cnt), .clr(clr), .over(over_u), .fault(fault_u), .fault_pulse(fault_pulse_u), .peak(peak_u)
`ifdef AVG_MON_TRIP_CNT_EN
      , .trip_cnt(trip_cnt_u)
`endif
   );

   task automatic do_reset(input logic [7:0] d, input logic [17:0] hi, input logic [17:0] lo);
      @(negedge clk);
      rst_n = 1'b0;
      ENA = 1'b0;
      clr = 1'b0;
      deb_cnt = d;
      thr_hi = hi;
      thr_lo = lo;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic ev(input logic [17:0] v);
      @(negedge clk);
      avg = v;
      ENA = 1'b1;
      @(negedge clk);
      ENA = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(8'd3, 18'd1000, 18'd800);
      n_cmp++; if ({over, fault, fault_pulse} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {over, fault, fault_pulse}); end
      n_cmp++; if (peak !== 18'h20000) begin n_err++; $display("FAIL reset_peak got %h exp 20000", peak); end
      n_cmp++; if (peak_u !== 18'h00000) begin n_err++; $display("FAIL reset_peak_u got %h exp 00000", peak_u); end
`ifdef AVG_MON_TRIP_CNT_EN
      n_cmp++; if (trip_cnt !== 16'd0) begin n_err++; $display("FAIL reset_trip_cnt got %0d exp 0", trip_cnt); end
`endif
   endtask

   task automatic test_trip;
      ev(18'd1200);
      ev(18'd1200);
      n_cmp++; if (over !== 1'b0 || fault_pulse !== 1'b0) begin n_err++; $display("FAIL trip_early over=%b pulse=%b exp 0 0", over, fault_pulse); end
      ev(18'd1200);
      n_cmp++; if ({over, fault, fault_pulse} !== 3'b111) begin n_err++; $display("FAIL trip_flags got %b exp 111", {over, fault, fault_pulse}); end
      n_cmp++; if (peak !== 18'd1200) begin n_err++; $display("FAIL trip_peak got %0d exp 1200", peak); end
      @(negedge clk);
      n_cmp++; if (fault_pulse !== 1'b0) begin n_err++; $display("FAIL trip_pulse_width got %b exp 0", fault_pulse); end
   endtask

   task automatic test_hold_release;
      repeat (5) ev(18'd900);
      n_cmp++; if (over !== 1'b1 || fault_pulse !== 1'b0) begin n_err++; $display("FAIL hyst_hold over=%b pulse=%b exp 1 0", over, fault_pulse); end
      n_cmp++; if (peak !== 18'd1200) begin n_err++; $display("FAIL peak_keep got %0d exp 1200", peak); end
      ev(18'd700);
      ev(18'd700);
      n_cmp++; if (over !== 1'b1) begin n_err++; $display("FAIL rel_pending got %b exp 1", over); end
      ev(18'd700);
      n_cmp++; if (over !== 1'b0 || fault !== 1'b1) begin n_err++; $display("FAIL released over=%b fault=%b exp 0 1", over, fault); end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++; if (fault !== 1'b0 || peak !== 18'h20000) begin n_err++; $display("FAIL clr fault=%b peak=%h exp 0 20000", fault, peak); end
   endtask

   task automatic test_no_trip;
      do_reset(8'd3, 18'd1000, 18'd800);
      ev(18'd1200);
      ev(18'd1200);
      ev(18'd900);
      n_cmp++; if (over !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL abort over=%b fault=%b exp 0 0", over, fault); end
      ev(18'd1200);
      ev(18'd1200);
      n_cmp++; if (over !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL abort_restart over=%b fault=%b exp 0 0", over, fault); end
   endtask

   task automatic test_sign;
      do_reset(8'd1, 18'd10, 18'd5);
      ev(18'h3FFFB);
      n_cmp++; if (over !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL signed_no_trip over=%b fault=%b exp 0 0", over, fault); end
      n_cmp++; if (over_u !== 1'b1 || fault_pulse_u !== 1'b1) begin n_err++; $display("FAIL unsigned_trip over=%b pulse=%b exp 1 1", over_u, fault_pulse_u); end
      n_cmp++; if (peak !== 18'h3FFFB) begin n_err++; $display("FAIL signed_peak got %h exp 3fffb", peak); end
   endtask

   task automatic test_ena_held(input logic [7:0] d);
      int pulses;
      do_reset(d, 18'd1000, 18'd800);
      pulses = 0;
      @(negedge clk);
      avg = 18'd1200;
      ENA = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 9) ENA = 1'b0;
         if (fault_pulse) pulses++;
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ena_held_deb%0d pulses got %0d exp 1", d, pulses); end
      n_cmp++; if (over !== 1'b1) begin n_err++; $display("FAIL ena_held_deb%0d over got %b exp 1", d, over); end
   endtask

   task automatic test_mid_reset_and_clr_trip;
      do_reset(8'd3, 18'd1000, 18'd800);
      ev(18'd1200);
      ev(18'd1200);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (peak !== 18'h20000) begin n_err++; $display("FAIL async_reset_peak got %h exp 20000", peak); end
      @(negedge clk);
      rst_n = 1'b1;
      ev(18'd1200);
      ev(18'd1200);
      n_cmp++; if (over !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL mid_reset over=%b fault=%b exp 0 0", over, fault); end
      @(negedge clk);
      avg = 18'd1200;
      ENA = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      ENA = 1'b0;
      clr = 1'b0;
      n_cmp++; if ({over, fault, fault_pulse} !== 3'b111) begin n_err++; $display("FAIL clr_trip flags got %b exp 111", {over, fault, fault_pulse}); end
      n_cmp++; if (peak !== 18'd1200) begin n_err++; $display("FAIL clr_event_peak got %0d exp 1200", peak); end
`ifdef AVG_MON_TRIP_CNT_EN
      n_cmp++; if (trip_cnt !== 16'd1) begin n_err++; $display("FAIL clr_trip_cnt got %0d exp 1", trip_cnt); end
`endif
   endtask

   task automatic test_deb_change;
      do_reset(8'd3, 18'd1000, 18'd800);
      ev(18'd1200);
      ev(18'd1200);
      deb_cnt = 8'd2;
      ev(18'd1200);
      n_cmp++; if (over !== 1'b1 || fault_pulse !== 1'b1) begin n_err++; $display("FAIL deb_change over=%b pulse=%b exp 1 1", over, fault_pulse); end
   endtask

`ifdef AVG_MON_TRIP_CNT_EN
   task automatic test_trip_cnt;
      do_reset(8'd1, 18'd1000, 18'd800);
      repeat (3) begin
         ev(18'd1200);
         ev(18'd700);
      end
      n_cmp++; if (trip_cnt !== 16'd3) begin n_err++; $display("FAIL trip_cnt got %0d exp 3", trip_cnt); end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++; if (trip_cnt !== 16'd0) begin n_err++; $display("FAIL trip_cnt_clr got %0d exp 0", trip_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_trip();
      test_hold_release();
      test_no_trip();
      test_sign();
      test_ena_held(8'd1);
      test_ena_held(8'd0);
      test_mid_reset_and_clr_trip();
      test_deb_change();
`ifdef AVG_MON_TRIP_CNT_EN
      test_trip_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/avg_threshold_monitor.md
Name: avg_threshold_monitor

Overview:
- Downstream consumer of the moving-average stage output (avg).
- On each qualified sample strobe, compares avg against a hysteresis window. Debounces crossings over a programmable number of consecutive strobes. Drives a live over-limit flag, a latched fault, a one-cycle fault pulse and a peak-hold register.
- Sits between the averaging stage and the protection/interrupt logic.

Parameters:
- DW, 18, data width of avg, thresholds and peak.
- US, 0, 0 = avg/thresholds signed two's complement; 1 = unsigned.
- DEB_W, 8, width of the debounce count input and the internal counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ENA  input  1  sample strobe; one event per 0->1 transition.
- avg  input  DW  averaged sample from the upstream stage.
- thr_hi  input  DW  trip threshold; crossing condition is avg > thr_hi.
- thr_lo  input  DW  release threshold; crossing condition is avg < thr_lo.
- deb_cnt  input  DEB_W  consecutive qualifying events required; 0 is treated as 1.
- clr  input  1  synchronous clear of fault and peak.
- over  output  1  debounced, hysteresis-filtered over-limit state.
- fault  output  1  latched fault.
- fault_pulse  output  1  one-cycle pulse on each trip.
- peak  output  DW  maximum avg seen at events since reset or clr.

Behaviour:
- Reset (async, rst_n=0):
  - over=0, fault=0, fault_pulse=0.
  - peak = most negative value (US=0: 1 followed by zeros) or 0 (US=1).
  - FSM=OK, debounce counter=0, ENA_old=0.
- Event detection:
  - ENA_old is a register tracking ENA.
  - event = ENA & ~ENA_old. ENA held high yields exactly one event.
- Sampling and latency:
  - avg, thr_hi and thr_lo are sampled only in the event cycle.
  - All outputs are registered and change on the clock edge that ends the event cycle.
- Comparisons: signed when US=0, unsigned when US=1, full DW bits.
- Effective debounce: N = max(deb_cnt, 1).
- FSM states: OK, PEND_TRIP, TRIPPED, PEND_REL. The FSM advances only on events.
  - OK:
    - event & hi_cross, N=1 -> TRIPPED.
    - event & hi_cross, N>1 -> PEND_TRIP, cnt=1.
  - PEND_TRIP:
    - event & hi_cross -> cnt+1; when cnt+1 reaches N -> TRIPPED, cnt=0.
    - event & ~hi_cross -> OK, cnt=0.
  - TRIPPED:
    - event & lo_cross, N=1 -> OK.
    - event & lo_cross, N>1 -> PEND_REL, cnt=1.
  - PEND_REL:
    - event & lo_cross -> cnt+1; when cnt+1 reaches N -> OK, cnt=0.
    - event & ~lo_cross -> TRIPPED, cnt=0.
- Outputs vs. state:
  - over=1 in TRIPPED and PEND_REL; 0 in OK and PEND_TRIP.
  - fault_pulse=1 for exactly the one cycle after entry into TRIPPED from PEND_TRIP or OK. No pulse on PEND_REL->TRIPPED.
  - fault sets on entry into TRIPPED and stays set until clr. It does not clear when over drops.
- Simultaneous events:
  - clr in the same cycle as a trip: fault ends at 1 (set wins).
  - clr in the same cycle as an event: peak loads that event's avg.
- peak:
  - On an event with avg > peak, peak <= avg.
  - On clr with no event, peak returns to its reset value.
- deb_cnt changed mid-debounce: the new value applies immediately. If cnt+1 is already >= N, the transition completes on the next qualifying event.
- thr_lo > thr_hi is a misconfiguration. Rules are applied literally with no protection.
- Reset asserted mid-operation returns everything to reset values immediately, including the pending counter.

Optional Feature:
- Macro: AVG_MON_TRIP_CNT_EN.
- Defined: adds output port trip_cnt [15:0].
  - Reset 0; increments on every fault_pulse.
  - Saturates at 16'hFFFF.
  - clr zeroes it; clr and a trip in the same cycle -> 1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (DW=18, DEB_W=8, deb_cnt=3, thr_hi=1000, thr_lo=800 unless noted):
- Reset, then release -> over=0, fault=0, fault_pulse=0, peak=18'h20000 (US=0).
- 3 events with avg=1200 -> over=1, fault=1, fault_pulse high one cycle after the 3rd event, peak=1200. Variant: 2 events at 1200 then 1 at 900 -> no trip, FSM back to OK.
- After trip: 5 events at 900 -> over stays 1. Then 3 events at 700 -> over=0, fault stays 1. Pulse clr -> fault=0, peak=18'h20000.
- Sign handling: avg=18'h3FFFB (-5), thr_hi=10, deb_cnt=1, US=0 -> no trip. Same stimulus with US=1 -> trips (262139 > 10).
- ENA held high 10 cycles with avg=1200 and deb_cnt=1 -> a single event, one fault_pulse. deb_cnt=0 behaves identically to deb_cnt=1.
- Mid-operation and macro checks:
  - rst_n low after 2 qualifying events -> after release, 2 more events at 1200 do not trip (counter cleared).
  - clr in the same cycle as the trip -> fault=1.
  - With AVG_MON_TRIP_CNT_EN: 3 trips -> trip_cnt=3; clr -> 0.
